// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: reset PC, fetch state encoding, exception codes.
// S_HALT exists only when IF_ADEF_CHECK_EN is defined.
package cpu_defs_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
   localparam logic [5:0]  ECODE_ADEF       = 6'h08;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_RUN   = 2'd1,
      S_HOLD  = 2'd2
`ifdef IF_ADEF_CHECK_EN
      ,
      S_HALT  = 2'd3
`endif
   } fetch_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction SRAM port, redirect input and fetch->decode handshake.
// fs_adef exists only when IF_ADEF_CHECK_EN is defined.
interface if_fetch_stage_if;

   logic        inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
   logic        br_valid;
   logic [31:0] br_target;
   logic        ds_allow_in;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
`ifdef IF_ADEF_CHECK_EN
   logic        fs_adef;
`endif

   modport master (
`ifdef IF_ADEF_CHECK_EN
      output fs_adef,
`endif
      output inst_sram_we,
      output inst_sram_addr,
      output inst_sram_wdata,
      input  inst_sram_rdata,
      input  br_valid,
      input  br_target,
      input  ds_allow_in,
      output fs_to_ds_valid,
      output fs_pc,
      output fs_inst
   );

   modport slave (
`ifdef IF_ADEF_CHECK_EN
      input  fs_adef,
`endif
      input  inst_sram_we,
      input  inst_sram_addr,
      input  inst_sram_wdata,
      output inst_sram_rdata,
      output br_valid,
      output br_target,
      output ds_allow_in,
      input  fs_to_ds_valid,
      input  fs_pc,
      input  fs_inst
   );

endinterface

// File: rtl/if_fetch_stage_inst_buf.sv
// One-entry instruction buffer holding the offered word while decode stalls.
// Clear has priority over load.
module if_inst_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] din,
   output logic [31:0] data,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid <= 1'b0;
         data  <= 32'h0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the synchronous instruction
// SRAM and offers one instruction at a time to decode. Optional macro: IF_ADEF_CHECK_EN.
module if_fetch_stage
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   if_fetch_stage_if.master  bus
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  pc_r;
   logic [31:0]  pc_next;
   logic [31:0]  pc_inc;
   logic [31:0]  addr;
   logic [31:0]  inst;
   logic [31:0]  pc_out;
   logic         valid;
   logic         hs;
   logic         buf_load;
   logic         buf_clear;
   logic         buf_valid;
   logic [31:0]  buf_data;
`ifdef IF_ADEF_CHECK_EN
   logic         adef_r;
   logic         adef_next;
`endif

   assign pc_inc = pc_r + 32'd4;

   if_inst_buf u_buf (
      .clk   (clk),
      .reset (reset),
      .load  (buf_load),
      .clear (buf_clear),
      .din   (bus.inst_sram_rdata),
      .data  (buf_data),
      .valid (buf_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_RESET;
         pc_r   <= RESET_PC;
`ifdef IF_ADEF_CHECK_EN
         adef_r <= 1'b0;
`endif
      end else begin
         state  <= state_next;
         pc_r   <= pc_next;
`ifdef IF_ADEF_CHECK_EN
         adef_r <= adef_next;
`endif
      end
   end

   // Offer first, then the handshake-driven transition, then redirect and reset overrides.
   always_comb begin
      state_next = state;
      pc_next    = pc_r;
      addr       = word_align(pc_inc);
      inst       = 32'h0;
      pc_out     = pc_r;
      valid      = 1'b0;
      hs         = 1'b0;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;
`ifdef IF_ADEF_CHECK_EN
      adef_next  = adef_r;
`endif

      case (state)
         S_RESET: begin
            addr       = RESET_PC;
            pc_next    = RESET_PC;
            buf_clear  = 1'b1;
            state_next = S_RUN;
         end
         S_RUN: begin
            valid = 1'b1;
            inst  = bus.inst_sram_rdata;
            hs    = bus.ds_allow_in;
`ifdef IF_ADEF_CHECK_EN
            if (adef_r) begin
               // A faulted word is never fetched; park until decode takes it, then halt.
               inst = 32'h0;
               addr = word_align(pc_r);
               if (hs) begin
                  state_next = S_HALT;
               end
            end else
`endif
            if (hs) begin
               pc_next = pc_inc;
            end else begin
               buf_load   = 1'b1;
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            valid = buf_valid;
            inst  = buf_data;
            hs    = buf_valid & bus.ds_allow_in;
            if (hs) begin
               pc_next    = pc_inc;
               buf_clear  = 1'b1;
               state_next = S_RUN;
            end
         end
`ifdef IF_ADEF_CHECK_EN
         S_HALT: begin
            addr = word_align(pc_r);
         end
`endif
         default: begin
            addr       = RESET_PC;
            state_next = S_RESET;
         end
      endcase

      if (bus.br_valid && (state != S_RESET)) begin
         valid      = 1'b0;
         hs         = 1'b0;
         addr       = word_align(bus.br_target);
         pc_next    = bus.br_target;
         buf_load   = 1'b0;
         buf_clear  = 1'b1;
         state_next = S_RUN;
`ifdef IF_ADEF_CHECK_EN
         adef_next  = |bus.br_target[1:0];
`endif
      end

      if (reset) begin
         valid      = 1'b0;
         hs         = 1'b0;
         addr       = RESET_PC;
         inst       = 32'h0;
         pc_out     = RESET_PC;
         buf_load   = 1'b0;
         buf_clear  = 1'b1;
         state_next = S_RESET;
      end
   end

   assign bus.inst_sram_we    = 1'b0;
   assign bus.inst_sram_wdata = 32'h0;
   assign bus.inst_sram_addr  = addr;
   assign bus.fs_to_ds_valid  = valid;
   assign bus.fs_pc           = pc_out;
   assign bus.fs_inst         = inst;
`ifdef IF_ADEF_CHECK_EN
   assign bus.fs_adef         = valid & adef_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a one-cycle-latency SRAM model.
// Covers both builds of IF_ADEF_CHECK_EN.
module tb_if_fetch_stage;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   if_fetch_stage_if bus ();

   if_fetch_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] sram_word(input logic [31:0] a);
      return a ^ 32'hdead_beef;
   endfunction

   always @(posedge clk) begin
      bus.inst_sram_rdata <= sram_word(bus.inst_sram_addr);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic rst, input logic br_v,
                                 input logic [31:0] br_t, input logic allow);
      reset           = rst;
      bus.br_valid    = br_v;
      bus.br_target   = br_t;
      bus.ds_allow_in = allow;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_offer(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst, input logic [31:0] addr);
      check_output({tag, "_valid"}, {31'b0, bus.fs_to_ds_valid}, 32'd1);
      check_output({tag, "_pc"}, bus.fs_pc, pc);
      check_output({tag, "_inst"}, bus.fs_inst, inst);
      check_output({tag, "_addr"}, bus.inst_sram_addr, addr);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;

      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
      step();
      check_output("rst_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
      check_output("rst_pc", bus.fs_pc, 32'h1c00_0000);
      check_output("rst_inst", bus.fs_inst, 32'h0);
      check_output("rst_addr", bus.inst_sram_addr, 32'h1c00_0000);
      check_output("rst_we", {31'b0, bus.inst_sram_we}, 32'd0);
      check_output("rst_wdata", bus.inst_sram_wdata, 32'h0);
`ifdef IF_ADEF_CHECK_EN
      check_output("rst_adef", {31'b0, bus.fs_adef}, 32'd0);
`endif
      step();
      step();

      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      check_output("sreset_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
      check_output("sreset_addr", bus.inst_sram_addr, 32'h1c00_0000);

      step();
      check_offer("run0", 32'h1c00_0000, sram_word(32'h1c00_0000), 32'h1c00_0004);
      step();
      check_offer("run4", 32'h1c00_0004, sram_word(32'h1c00_0004), 32'h1c00_0008);
      step();

      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
      check_offer("stall0", 32'h1c00_0008, sram_word(32'h1c00_0008), 32'h1c00_000c);
      for (int i = 0; i < 3; i++) begin
         step();
         check_offer("hold", 32'h1c00_0008, sram_word(32'h1c00_0008), 32'h1c00_000c);
      end
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      check_offer("hold_hs", 32'h1c00_0008, sram_word(32'h1c00_0008), 32'h1c00_000c);
      step();
      check_offer("nobubble", 32'h1c00_000c, sram_word(32'h1c00_000c), 32'h1c00_0010);

      step();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0);
      check_offer("stall10", 32'h1c00_0010, sram_word(32'h1c00_0010), 32'h1c00_0014);
      step();
      apply_stimulus(1'b0, 1'b1, 32'h1c00_0100, 1'b1);
      check_output("br_hold_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
      check_output("br_hold_addr", bus.inst_sram_addr, 32'h1c00_0100);
      step();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      check_offer("br_tgt", 32'h1c00_0100, sram_word(32'h1c00_0100), 32'h1c00_0104);

      apply_stimulus(1'b0, 1'b1, 32'h1c00_0040, 1'b1);
      check_output("br_run_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
      check_output("br_run_addr", bus.inst_sram_addr, 32'h1c00_0040);
      step();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      check_offer("br_tgt40", 32'h1c00_0040, sram_word(32'h1c00_0040), 32'h1c00_0044);

      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b1);
      check_output("midrst_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
      check_output("midrst_addr", bus.inst_sram_addr, 32'h1c00_0000);
      step();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      check_output("post_rst_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
      check_output("post_rst_addr", bus.inst_sram_addr, 32'h1c00_0000);
      check_output("post_rst_pc", bus.fs_pc, 32'h1c00_0000);
      step();
      check_offer("resume", 32'h1c00_0000, sram_word(32'h1c00_0000), 32'h1c00_0004);

      apply_stimulus(1'b0, 1'b1, 32'hffff_fffc, 1'b1);
      check_output("br_wrap_addr", bus.inst_sram_addr, 32'hffff_fffc);
      step();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      check_offer("wrap_top", 32'hffff_fffc, sram_word(32'hffff_fffc), 32'h0000_0000);
      step();
      check_offer("wrap_zero", 32'h0000_0000, sram_word(32'h0000_0000), 32'h0000_0004);

      apply_stimulus(1'b0, 1'b1, 32'h1c00_0102, 1'b1);
      check_output("br_mis_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
      check_output("br_mis_addr", bus.inst_sram_addr, 32'h1c00_0100);
      step();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef IF_ADEF_CHECK_EN
      check_offer("adef", 32'h1c00_0102, 32'h0, 32'h1c00_0100);
      check_output("adef_flag", {31'b0, bus.fs_adef}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         step();
         check_output("halt_valid", {31'b0, bus.fs_to_ds_valid}, 32'd0);
         check_output("halt_addr", bus.inst_sram_addr, 32'h1c00_0100);
         check_output("halt_adef", {31'b0, bus.fs_adef}, 32'd0);
      end
      apply_stimulus(1'b0, 1'b1, 32'h1c00_0200, 1'b1);
      check_output("halt_br_addr", bus.inst_sram_addr, 32'h1c00_0200);
      step();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1);
      check_offer("unhalt", 32'h1c00_0200, sram_word(32'h1c00_0200), 32'h1c00_0204);
      check_output("unhalt_adef", {31'b0, bus.fs_adef}, 32'd0);
`else
      check_offer("mis", 32'h1c00_0102, sram_word(32'h1c00_0100), 32'h1c00_0104);
      step();
      check_offer("mis_next", 32'h1c00_0106, sram_word(32'h1c00_0104), 32'h1c00_0108);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
